// File: rtl/chg_chain_seq_if.sv
// chg_chain_seq_if: handshake and data bundle between the increment-chain
// sequencer and its environment (test top plus the chain under test).
// Signal names carry the direction seen from the sequencer (i_ = into it,
// o_ = out of it). The sequencer uses the slave modport and the environment
// uses the master modport.
interface chg_chain_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             i_start;
    logic [WIDTH-1:0] i_base;
    logic [WIDTH-1:0] i_chain;
    logic [WIDTH-1:0] o_seed;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [7:0]       o_err_count;
    logic [7:0]       o_vec_idx;

    modport master (
        output i_start, i_base, i_chain,
        input  o_seed, o_busy, o_done, o_pass, o_err_count, o_vec_idx
    );

    modport slave (
        input  i_start, i_base, i_chain,
        output o_seed, o_busy, o_done, o_pass, o_err_count, o_vec_idx
    );
endinterface

// File: rtl/chg_chain_seq.sv
// chg_chain_seq: drives NUM_VEC consecutive seeds into an N-stage "+1"
// combinational chain, waits SETTLE cycles per seed, then checks that the
// chain returned seed + STAGES (mod 2^WIDTH). Reports busy/done/pass and a
// saturating mismatch count. Every output comes straight from a flop.
//
// Optional build macro: CHG_SEQ_STOP_ON_FAIL_EN
//   defined   -> the first mismatching vector ends the run immediately
//                (err_count = 1, vec_idx holds the failing index).
//   undefined -> every vector is checked and mismatches accumulate.
module chg_chain_seq #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 6,
    parameter int SETTLE  = 2,   // legal 1..15
    parameter int NUM_VEC = 8    // legal 1..255
) (
    input  logic             i_clk,
    input  logic             i_reset_l,
    chg_chain_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0]       LAST_IDX    = 8'(NUM_VEC - 1);
    localparam logic [WIDTH-1:0] STAGE_OFS   = WIDTH'(STAGES);

    // Value a healthy chain must return for a given seed (wraps naturally).
    function automatic logic [WIDTH-1:0] expected_of(input logic [WIDTH-1:0] seed);
        return seed + STAGE_OFS;
    endfunction

    // Error counter increment that sticks at the all-ones ceiling.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt == 8'hFF) begin
            return cnt;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

    state_t           r_state;
    logic [3:0]       r_settle_cnt;
    logic [WIDTH-1:0] r_seed;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_err_count;
    logic [7:0]       r_vec_idx;

    logic [WIDTH-1:0] w_expect;
    logic             w_mismatch;
    logic [7:0]       w_err_next;
    logic             w_last_vec;

    // Compare the returning chain value against the expected offset seed.
    always_comb begin
        w_expect   = expected_of(r_seed);
        w_mismatch = (bus.i_chain != w_expect);
        w_last_vec = (r_vec_idx == LAST_IDX);
        if (w_mismatch) begin
            w_err_next = sat_inc(r_err_count);
        end else begin
            w_err_next = r_err_count;
        end
    end

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_l) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_seed       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 8'd0;
            r_vec_idx    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A new run may start from rest or straight out of DONE.
                    if (bus.i_start) begin
                        r_state     <= ST_DRIVE;
                        r_seed      <= bus.i_base;
                        r_vec_idx   <= 8'd0;
                        r_err_count <= 8'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_DRIVE: begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_err_count <= w_err_next;
`ifdef CHG_SEQ_STOP_ON_FAIL_EN
                    if (w_mismatch || w_last_vec) begin
`else
                    if (w_last_vec) begin
`endif
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 8'd0);
                    end else begin
                        r_state   <= ST_DRIVE;
                        r_vec_idx <= r_vec_idx + 8'd1;
                        r_seed    <= r_seed + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_seed      = r_seed;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_pass      = r_pass;
    assign bus.o_err_count = r_err_count;
    assign bus.o_vec_idx   = r_vec_idx;

endmodule
